// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a 2**ADDR_W x 32-bit word memory.
// Serves one burst at a time, alternating read/write grants when both address channels request.
`timescale 1ns/1ps
module axi_sram_slave #(
    parameter int ADDR_W = 10,
    parameter int ID_W   = 4
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,

    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,

    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RDATA = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] WRESP = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [31:0]       r_mem [0:DEPTH-1];

    logic [1:0]        r_state;
    logic [ID_W-1:0]   r_id;
    logic [31:0]       r_addr;
    logic [7:0]        r_len;
    logic [1:0]        r_burst;
    logic [7:0]        r_cnt;
    logic              r_wr_decerr;
    logic              r_wr_slverr;
    logic              r_wr_last;

    logic              w_addr_oor;
    logic [ADDR_W-1:0] w_word;
    logic              w_beat_last;
    logic [31:0]       w_next_addr;
    logic [7:0]        w_next_cnt;
    logic              w_rd_grant;
    logic              w_wr_grant;
    logic              w_ar_hs;
    logic              w_aw_hs;
    logic              w_r_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_mem_we;
    logic              w_unused;

    // Handshake rule on every channel: a transfer happens on the rising edge
    // where valid and ready are both high; the source holds its payload
    // stable while valid is high and ready is low.

    assign w_unused = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot};

    assign w_addr_oor  = |r_addr[31:ADDR_W+2];
    assign w_word      = r_addr[ADDR_W+1:2];
    assign w_beat_last = (r_cnt == r_len);
    assign w_next_addr = (r_burst == BURST_FIXED) ? r_addr : r_addr + 32'd4;
    assign w_next_cnt  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // r_wr_last=1 means the last served transaction was a write, so a read wins a tie.
    assign w_rd_grant = arvalid && (!awvalid || r_wr_last);
    assign w_wr_grant = awvalid && !w_rd_grant;

    assign arready = !areset && (r_state == IDLE) && w_rd_grant;
    assign awready = !areset && (r_state == IDLE) && w_wr_grant;

    assign w_ar_hs = arvalid && arready;
    assign w_aw_hs = awvalid && awready;

    assign rvalid = (r_state == RDATA);
    assign rid    = r_id;
    assign rlast  = rvalid && w_beat_last;
    assign rdata  = (rvalid && !w_addr_oor) ? r_mem[w_word] : 32'd0;

    always_comb begin
        rresp = RESP_OKAY;
        if (rvalid) begin
            if (w_addr_oor)
                rresp = RESP_DECERR;
            else if (r_burst[1])
                rresp = RESP_SLVERR;
        end
    end

    assign wready = (r_state == WDATA);
    assign bvalid = (r_state == WRESP);
    assign bid    = r_id;

    always_comb begin
        bresp = RESP_OKAY;
        if (bvalid) begin
            if (r_wr_decerr)
                bresp = RESP_DECERR;
            else if (r_wr_slverr)
                bresp = RESP_SLVERR;
        end
    end

    assign w_r_hs = rvalid && rready;
    assign w_w_hs = wvalid && wready;
    assign w_b_hs = bvalid && bready;

    assign dbg_state = r_state;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= IDLE;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
            r_wr_decerr <= 1'b0;
            r_wr_slverr <= 1'b0;
            r_wr_last   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ar_hs) begin
                        r_id      <= arid;
                        r_addr    <= araddr;
                        r_len     <= arlen;
                        r_burst   <= arburst;
                        r_cnt     <= '0;
                        r_wr_last <= 1'b0;
                        r_state   <= RDATA;
                    end else if (w_aw_hs) begin
                        r_id        <= awid;
                        r_addr      <= awaddr;
                        r_len       <= awlen;
                        r_burst     <= awburst;
                        r_cnt       <= '0;
                        r_wr_decerr <= 1'b0;
                        r_wr_slverr <= awburst[1];
                        r_wr_last   <= 1'b1;
                        r_state     <= WDATA;
                    end
                end
                RDATA: begin
                    if (w_r_hs) begin
                        if (w_beat_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt  <= w_next_cnt;
                            r_addr <= w_next_addr;
                        end
                    end
                end
                WDATA: begin
                    if (w_w_hs) begin
                        if (w_addr_oor)
                            r_wr_decerr <= 1'b1;
                        if ((wid != r_id) || (wlast != w_beat_last))
                            r_wr_slverr <= 1'b1;
                        // Only wlast closes the burst; a miscounted burst keeps going.
                        if (wlast) begin
                            r_state <= WRESP;
                        end else begin
                            r_cnt  <= w_next_cnt;
                            r_addr <= w_next_addr;
                        end
                    end
                end
                WRESP: begin
                    if (w_b_hs)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_mem_we = w_w_hs && !w_addr_oor;

    // Memory has no reset so contents survive areset.
    always_ff @(posedge aclk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_mem_we && wstrb[b])
                r_mem[w_word][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory holds 2**ADDR_W 32-bit words.
REQ-002 Parameter ID_W, default 4, AXI ID width.
REQ-003 aclk  input  1  sole clock; all logic on rising edge.
REQ-004 areset  input  1  reset; asynchronous assert, active-high, synchronous release.
REQ-005 arid/araddr/arlen/arsize/arburst  input  ID_W/32/8/3/2  read address channel.
REQ-006 arlock/arcache/arprot  input  2/4/3  accepted, ignored.
REQ-007 arvalid  input  1;  arready  output  1.
REQ-008 rid/rdata/rresp/rlast/rvalid  output  ID_W/32/2/1/1;  rready  input  1.
REQ-009 awid/awaddr/awlen/awsize/awburst  input  ID_W/32/8/3/2;  awlock/awcache/awprot  input  2/4/3, ignored.
REQ-010 awvalid  input  1;  awready  output  1.
REQ-011 wid/wdata/wstrb/wlast/wvalid  input  ID_W/32/4/1/1;  wready  output  1.
REQ-012 bid/bresp/bvalid  output  ID_W/2/1;  bready  input  1.

Function
REQ-013 FSM states IDLE, RDATA, WDATA, WRESP; one transaction outstanding at a time.
REQ-014 IDLE: arready=1 iff arvalid and read granted; awready=1 iff awvalid and write granted; never both.
REQ-015 Arbitration, IDLE with arvalid and awvalid both high: grant the type not served last (1-bit flag, reset value = write served last, so read wins first).
REQ-016 AR handshake: latch id, addr, len, burst; beat counter=0; go RDATA; rvalid rises next cycle.
REQ-017 RDATA: rdata = mem[addr[ADDR_W+1:2]]; rid=latched id; rlast=1 iff beat counter==len.
REQ-018 R handshake, not last: counter+1; addr+4 if burst INCR or WRAP, unchanged if FIXED; rvalid stays 1 (1 beat/cycle).
REQ-019 R handshake with rlast: rvalid=0 next cycle, return to IDLE.
REQ-020 rvalid, rdata, rresp, rlast, rid SHALL hold stable while rvalid=1 and rready=0.
REQ-021 Address out of range (addr[31:ADDR_W+2]!=0): rdata=0, rresp=2'b11 (DECERR) for that beat.
REQ-022 burst WRAP (2'b10) or reserved (2'b11): processed as INCR, rresp/bresp=2'b10 (SLVERR) unless DECERR applies; DECERR takes priority.
REQ-023 Sub-word arsize: full aligned word returned; addr[1:0] ignored; increment stays 4.
REQ-024 AW handshake: latch id, addr, len, burst; counter=0; error flags cleared; go WDATA; wready=1 from next cycle.
REQ-025 W handshake: bytes with wstrb[i]=1 written to mem word, others unchanged; address/counter update as REQ-018.
REQ-026 Out-of-range write beat: data dropped, DECERR flag set.
REQ-027 wid!=latched id, or wlast disagreeing with (counter==len): beat still written, SLVERR flag set.
REQ-028 Burst ends on the W handshake with wlast=1 only; wready=0 next cycle, go WRESP.
REQ-029 WRESP: bvalid=1, bid=latched id, bresp=DECERR if flagged, else SLVERR if flagged, else 2'b00; hold until bready; then IDLE.
REQ-030 Read after write to same word (separate transactions) SHALL return written data.
REQ-031 arlen/awlen up to 255 supported; counter 8 bits, no wrap within a burst.

Reset
REQ-032 While areset=1: state IDLE; arready, awready, wready, rvalid, bvalid, rlast = 0; rresp, bresp = 2'b00; rid, bid, rdata = 0; arbitration flag = write.
REQ-033 Reset mid-burst abandons the transaction; memory contents not reset and not altered by reset.

Verification
REQ-034 Write awaddr=0x10, awlen=3, INCR, wdata 0xA0..0xA3, wstrb=4'hF -> bresp=0, bid=awid; read same burst returns 0xA0..0xA3, rlast on beat 3 only.
REQ-035 Single write 0x11223344 then wstrb=4'b0101 with 0xAABBCCDD to same word -> read returns 0x11BB33DD.
REQ-036 arvalid and awvalid asserted same cycle after reset -> read accepted first, then write; repeat -> alternate.
REQ-037 Read araddr=0x0001_0000 (ADDR_W=10), arlen=1 -> two beats rdata=0, rresp=2'b11; write there -> bresp=2'b11, memory unchanged.
REQ-038 rready toggled 0/1 randomly during arlen=7 read -> outputs stable when stalled, 8 beats, data in order.
REQ-039 areset pulsed during beat 2 of a 4-beat write -> all valid/ready 0 immediately; beats 0-1 retained in memory, new transactions accepted after release.
